dds_multiwave: RTL and testbench

DDS_MULTIWAVE -- requirements
Module: dds_multiwave

---
 rtl/dds_multiwave.sv | 175 +++++++++++++++++
 tb/tb_dds_multiwave.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_multiwave.sv
// Multi-waveform DDS: phase accumulator, sine/square/triangle/sawtooth generation,
// debounced frequency keys and an automatic frequency sweep.
module dds_multiwave #(
  parameter int                 PHASE_W   = 32,
  parameter int                 AMP_W     = 8,
  parameter int                 LUT_AW    = 8,
  parameter logic [PHASE_W-1:0] FCW_RESET = 32'h0100_0000,
  parameter logic [PHASE_W-1:0] FCW_STEP  = 32'h0100_0000,
  parameter logic [PHASE_W-1:0] FCW_MIN   = 32'h0100_0000,
  parameter logic [PHASE_W-1:0] FCW_MAX   = 32'h0400_0000,
  parameter int                 DEB_CYC   = 240000,
  parameter int                 SWEEP_DIV = 24000
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [1:0]         mode,
  input  logic               sweep_en,
  input  logic               key_plus,
  input  logic               key_down,
  output logic [LUT_AW-1:0]  rom_addr,
  input  logic [AMP_W-1:0]   rom_data,
  output logic [AMP_W-1:0]   num,
  output logic [PHASE_W-1:0] fcw,
  output logic [1:0]         led
);

  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam int DIV_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [DEB_W-1:0] DEB_FULL = DEB_W'(DEB_CYC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SWEEP_DIV - 1);
  localparam logic [PHASE_W:0] STEP_X   = {1'b0, FCW_STEP};
  localparam logic [PHASE_W:0] MIN_X    = {1'b0, FCW_MIN};
  localparam logic [PHASE_W:0] MAX_X    = {1'b0, FCW_MAX};

  typedef enum logic {MANUAL = 1'b0, SWEEP = 1'b1} state_t;

  state_t             state_reg, state_next;
  logic [PHASE_W-1:0] phase_reg;
  logic [PHASE_W-1:0] fcw_reg, fcw_next;
  logic [DIV_W-1:0]   div_reg, div_next;
  logic [1:0]         led_next;
  logic [1:0]         key_raw;
  logic [1:0]         press;

  // ---------------- waveform datapath ----------------
  logic             phase_msb;
  logic [AMP_W-1:0] saw_wave, tri_half, tri_wave, sq_wave;
  logic [AMP_W-1:0] saw_d1_reg, tri_d1_reg, sq_d1_reg;
  logic [AMP_W-1:0] saw_d2_reg, tri_d2_reg, sq_d2_reg;
  logic [AMP_W-1:0] num_next;

  assign phase_msb = phase_reg[PHASE_W-1];
  assign saw_wave  = phase_reg[PHASE_W-1 -: AMP_W];
  assign tri_half  = phase_reg[PHASE_W-2 -: AMP_W];
  assign tri_wave  = phase_msb ? ~tri_half : tri_half;
  assign sq_wave   = {AMP_W{phase_msb}};

  // Non-sine samples wait two stages so every mode matches the ROM read latency.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      phase_reg  <= '0;
      rom_addr   <= '0;
      saw_d1_reg <= '0;
      tri_d1_reg <= '0;
      sq_d1_reg  <= '0;
      saw_d2_reg <= '0;
      tri_d2_reg <= '0;
      sq_d2_reg  <= '0;
      num        <= '0;
    end else begin
      phase_reg  <= phase_reg + fcw_reg;
      rom_addr   <= phase_reg[PHASE_W-1 -: LUT_AW];
      saw_d1_reg <= saw_wave;
      tri_d1_reg <= tri_wave;
      sq_d1_reg  <= sq_wave;
      saw_d2_reg <= saw_d1_reg;
      tri_d2_reg <= tri_d1_reg;
      sq_d2_reg  <= sq_d1_reg;
      num        <= num_next;
    end
  end

  always_comb begin
    num_next = rom_data;
    case (mode)
      2'b01:   num_next = sq_d2_reg;
      2'b10:   num_next = tri_d2_reg;
      2'b11:   num_next = saw_d2_reg;
      default: num_next = rom_data;
    endcase
  end

  // ---------------- key synchronise + debounce ----------------
  assign key_raw = {key_down, key_plus};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      logic             sync1_reg, sync2_reg, press_reg;
      logic [DEB_W-1:0] cnt_reg;

      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          press_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= key_raw[gi];
          sync2_reg <= sync1_reg;
          // Pulse only on the transition into the full count; a held key saturates.
          press_reg <= ~sync2_reg && (cnt_reg == DEB_LAST);
          if (sync2_reg)
            cnt_reg <= '0;
          else if (cnt_reg != DEB_FULL)
            cnt_reg <= cnt_reg + DEB_W'(1);
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  // ---------------- frequency control FSM ----------------
  logic [PHASE_W:0] fcw_up_x;
  assign fcw_up_x = {1'b0, fcw_reg} + STEP_X;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg <= MANUAL;
      fcw_reg   <= FCW_RESET;
      div_reg   <= '0;
      led       <= 2'b11;
    end else begin
      state_reg <= state_next;
      fcw_reg   <= fcw_next;
      div_reg   <= div_next;
      led       <= led_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fcw_next   = fcw_reg;
    div_next   = div_reg;
    case (state_reg)
      MANUAL: begin
        if (sweep_en)
          state_next = SWEEP;
        div_next = '0;
        if (press[0] && !press[1])
          fcw_next = (fcw_up_x > MAX_X) ? FCW_MAX : fcw_up_x[PHASE_W-1:0];
        else if (press[1] && !press[0])
          fcw_next = ({1'b0, fcw_reg} < MIN_X + STEP_X) ? FCW_MIN : fcw_reg - FCW_STEP;
      end
      SWEEP: begin
        if (!sweep_en)
          state_next = MANUAL;
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          fcw_next = (fcw_up_x > MAX_X) ? FCW_MIN : fcw_up_x[PHASE_W-1:0];
        end else begin
          div_next = div_reg + DIV_W'(1);
        end
      end
      default: state_next = MANUAL;
    endcase
    // LEDs are registered from next-state values so they track fcw/state without lag.
    led_next = {~(fcw_next == FCW_MIN || fcw_next == FCW_MAX), ~(state_next == SWEEP)};
  end

  assign fcw = fcw_reg;

endmodule

// File: tb/tb_dds_multiwave.sv
// Scoreboard bench for dds_multiwave: directed waveform, key, sweep and reset vectors.
module tb_dds_multiwave;

  logic        clk;
  logic        sys_rst;
  logic [1:0]  mode;
  logic        sweep_en;
  logic        key_plus;
  logic        key_down;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  num;
  logic [31:0] fcw;
  logic [1:0]  led;

  localparam int K_NUM = 0;
  localparam int K_FCW = 1;
  localparam int K_LED = 2;
  localparam int K_ADR = 3;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } sb_item_t;

  sb_item_t sb_q[$];
  sb_item_t item;
  int       cyc;
  int       n_checks;
  int       n_pass;
  int       base;

  dds_multiwave #(
    .DEB_CYC  (4),
    .SWEEP_DIV(16)
  ) dut (
    .sys_clk (clk),
    .sys_rst (sys_rst),
    .mode    (mode),
    .sweep_en(sweep_en),
    .key_plus(key_plus),
    .key_down(key_down),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .num     (num),
    .fcw     (fcw),
    .led     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Test sine table (any known contents suffice) behind a registered read.
  function automatic logic [7:0] rom_val(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  always @(posedge clk) rom_data <= rom_val(int'(rom_addr));

  function automatic logic [7:0] exp_wave(input int m, input int idx);
    case (m)
      0:       return rom_val(idx);
      1:       return (idx >= 128) ? 8'hFF : 8'h00;
      2:       return (idx < 128) ? 8'(idx * 2) : 8'(255 - 2 * (idx - 128));
      default: return 8'(idx);
    endcase
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_NUM:   return "num";
      K_FCW:   return "fcw";
      K_LED:   return "led";
      default: return "rom_addr";
    endcase
  endfunction

  task automatic push(input int c, input int k, input logic [31:0] v);
    sb_item_t it;
    it.cyc  = c;
    it.kind = k;
    it.val  = v;
    sb_q.push_back(it);
  endtask

  // Monitor: compares every queued expectation due at the current cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      logic [31:0] act;
      item = sb_q.pop_front();
      case (item.kind)
        K_NUM:   act = {24'd0, num};
        K_FCW:   act = fcw;
        K_LED:   act = {30'd0, led};
        default: act = {24'd0, rom_addr};
      endcase
      n_checks++;
      if (item.cyc != cyc)
        $display("FAIL %s missed: due cyc=%0d seen cyc=%0d", kname(item.kind), item.cyc, cyc);
      else if (act !== item.val)
        $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h",
                 kname(item.kind), cyc, act, item.val);
      else
        n_pass++;
    end
  end

  // Phase index (top byte) after a given edge while fcw stays at 0x0100_0000.
  function automatic int idx_at(input int e);
    return (e - base) & 255;
  endfunction

  task automatic run_mode(input int m, input int n);
    int c;
    c = cyc;
    mode = 2'(m);
    for (int e = c + 1; e <= c + n; e++) begin
      push(e, K_NUM, {24'd0, exp_wave(m, idx_at(e - 3))});
      if (m == 0) push(e, K_ADR, {24'd0, 8'(idx_at(e - 1))});
    end
    $display("mode %0d: %0d samples queued from cyc %0d", m, n, c + 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic p, input logic d, input int len,
                       input logic [31:0] prev, input logic [31:0] exp_fcw,
                       input logic [1:0] exp_led);
    int c;
    c = cyc;
    push(c + 6, K_FCW, prev);
    push(c + 7, K_FCW, exp_fcw);
    push(c + 8, K_LED, {30'd0, exp_led});
    key_plus = ~p;
    key_down = ~d;
    repeat (len) @(negedge clk);
    key_plus = 1'b1;
    key_down = 1'b1;
    push(cyc + 8, K_FCW, exp_fcw);
    $display("press plus=%0b down=%0b len=%0d: expect fcw 0x%08h led %02b", p, d, len, exp_fcw, exp_led);
    repeat (12) @(negedge clk);
  endtask

  typedef struct {
    logic        p;
    logic        d;
    int          len;
    logic [31:0] fcw_e;
    logic [1:0]  led_e;
  } key_vec_t;

  key_vec_t key_tbl[10];

  initial begin
    int s;
    logic [31:0] prev;
    n_checks = 0;
    n_pass   = 0;
    sys_rst  = 1'b1;
    mode     = 2'b11;
    sweep_en = 1'b0;
    key_plus = 1'b1;
    key_down = 1'b1;

    key_tbl[0] = '{1'b1, 1'b0, 4,   32'h0200_0000, 2'b11};
    key_tbl[1] = '{1'b1, 1'b0, 100, 32'h0300_0000, 2'b11};
    key_tbl[2] = '{1'b1, 1'b0, 2,   32'h0300_0000, 2'b11};
    key_tbl[3] = '{1'b1, 1'b0, 4,   32'h0400_0000, 2'b01};
    key_tbl[4] = '{1'b1, 1'b0, 4,   32'h0400_0000, 2'b01};
    key_tbl[5] = '{1'b1, 1'b1, 4,   32'h0400_0000, 2'b01};
    key_tbl[6] = '{1'b0, 1'b1, 4,   32'h0300_0000, 2'b11};
    key_tbl[7] = '{1'b0, 1'b1, 4,   32'h0200_0000, 2'b11};
    key_tbl[8] = '{1'b0, 1'b1, 4,   32'h0100_0000, 2'b01};
    key_tbl[9] = '{1'b0, 1'b1, 4,   32'h0100_0000, 2'b01};

    repeat (3) @(negedge clk);
    push(cyc + 1, K_NUM, 32'h0);
    push(cyc + 1, K_ADR, 32'h0);
    push(cyc + 1, K_FCW, 32'h0100_0000);
    push(cyc + 1, K_LED, 32'h3);
    @(negedge clk);
    base    = cyc;
    sys_rst = 1'b0;
    $display("reset released at cyc %0d", base);
    push(base + 1, K_NUM, 32'h0);
    push(base + 1, K_LED, 32'h1);
    push(base + 2, K_NUM, 32'h0);
    repeat (2) @(negedge clk);

    run_mode(3, 38);
    run_mode(1, 260);
    run_mode(2, 260);
    run_mode(0, 260);

    prev = 32'h0100_0000;
    foreach (key_tbl[i]) begin
      press(key_tbl[i].p, key_tbl[i].d, key_tbl[i].len, prev, key_tbl[i].fcw_e, key_tbl[i].led_e);
      prev = key_tbl[i].fcw_e;
    end

    s = cyc;
    sweep_en = 1'b1;
    push(s + 2,  K_LED, 32'h0);
    push(s + 16, K_FCW, 32'h0100_0000);
    push(s + 17, K_FCW, 32'h0200_0000);
    push(s + 20, K_LED, 32'h2);
    push(s + 32, K_FCW, 32'h0200_0000);
    push(s + 33, K_FCW, 32'h0300_0000);
    push(s + 48, K_FCW, 32'h0300_0000);
    push(s + 49, K_FCW, 32'h0400_0000);
    push(s + 50, K_LED, 32'h0);
    push(s + 64, K_FCW, 32'h0400_0000);
    push(s + 65, K_FCW, 32'h0100_0000);
    $display("sweep started at cyc %0d", s);
    repeat (20) @(negedge clk);
    key_plus = 1'b0;
    repeat (4) @(negedge clk);
    key_plus = 1'b1;
    repeat (46) @(negedge clk);

    sys_rst = 1'b1;
    push(s + 71, K_NUM, 32'h0);
    push(s + 71, K_ADR, 32'h0);
    push(s + 71, K_FCW, 32'h0100_0000);
    push(s + 71, K_LED, 32'h3);
    push(s + 72, K_LED, 32'h0);
    push(s + 87, K_FCW, 32'h0100_0000);
    push(s + 88, K_FCW, 32'h0200_0000);
    $display("mid-sweep reset at cyc %0d", s + 71);
    @(negedge clk);
    sys_rst = 1'b0;
    repeat (19) @(negedge clk);
    sweep_en = 1'b0;
    push(s + 92,  K_LED, 32'h3);
    push(s + 100, K_FCW, 32'h0200_0000);
    $display("sweep stopped at cyc %0d", cyc);

    for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
